// File: rtl/mr_reg_seq.sv
// mr_reg_seq: register-transfer sequencer that turns MOV/LDI/SWAP/ACC commands into register-file read/write cycles
module mr_reg_seq #(
  parameter int              W          = 16,
  parameter int              ACC_CYCLES = 1,
  parameter logic [15:0]     ACC_ADDR   = 16'h0050
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [15:0]        cmd_a_i,
  input  logic [15:0]        cmd_b_i,
  input  logic [W-1:0]       cmd_imm_i,
  output logic [15:0]        src_o,
  output logic [15:0]        dst_o,
  output logic [W-1:0]       d_in_o,
  output logic               sto_o,
  output logic               sto_alu_o,
  input  logic [W-1:0]       d_out_i,
  output logic               done_o,
  output logic [W-1:0]       rd_data_o
);
  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_WR_A, S_WR_B, S_ACC, S_RD_ACC, S_DONE} state_t;
  localparam logic [1:0] OP_MOV  = 2'd0;
  localparam logic [1:0] OP_LDI  = 2'd1;
  localparam logic [1:0] OP_SWAP = 2'd2;
  localparam logic [3:0] ACC_N   = (ACC_CYCLES == 0) ? 4'd1 : 4'(ACC_CYCLES);
  state_t       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [15:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0] t0_q, t0_d, t1_q, t1_d, rd_q, rd_d;
  logic [3:0]   cnt_q, cnt_d;
  // State and operand registers; reset aborts any command in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end
  // Next-state logic: command capture, read-data latching and the ACC hold counter
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (cmd_valid_i) begin
        op_d    = cmd_op_i;
        a_d     = cmd_a_i;
        b_d     = cmd_b_i;
        t0_d    = cmd_imm_i;
        cnt_d   = ACC_N - 4'd1;
        state_d = cmd_op_i == OP_MOV ? S_RD_B : cmd_op_i == OP_LDI ? S_WR_A :
                  cmd_op_i == OP_SWAP ? S_RD_A : S_ACC;
      end
      S_RD_A: begin
        t0_d    = d_out_i;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        t0_d    = op_q == OP_SWAP ? t0_q : d_out_i;
        t1_d    = op_q == OP_SWAP ? d_out_i : t1_q;
        state_d = S_WR_A;
      end
      S_WR_A: state_d = op_q == OP_SWAP ? S_WR_B : S_DONE;
      S_WR_B: state_d = S_DONE;
      S_ACC: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? S_RD_ACC : S_ACC;
      end
      S_RD_ACC: begin
        t0_d    = d_out_i;
        state_d = S_DONE;
      end
      S_DONE: begin
        rd_d    = t0_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign cmd_ready_o = state_q == S_IDLE && !rst_i;
  assign src_o       = state_q == S_RD_A ? a_q : state_q == S_RD_B ? b_q :
                       state_q == S_RD_ACC ? ACC_ADDR : '0;
  assign dst_o       = state_q == S_WR_A ? a_q : state_q == S_WR_B ? b_q : '0;
  assign d_in_o      = state_q == S_WR_A ? (op_q == OP_SWAP ? t1_q : t0_q) :
                       state_q == S_WR_B ? t0_q : '0;
  assign sto_o       = state_q == S_WR_A || state_q == S_WR_B;
  assign sto_alu_o   = state_q == S_ACC;
  assign done_o      = state_q == S_DONE;
  assign rd_data_o   = state_q == S_DONE ? t0_q : rd_q;
endmodule

// File: tb/tb_mr_reg_seq.sv
// tb_mr_reg_seq: randomized and directed checks of mr_reg_seq against a register-file reference model
module tb_mr_reg_seq;
  localparam int          W      = 16;
  localparam int          ACC_CY = 3;
  localparam logic [15:0] ACC_AD = 16'h0050;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [15:0] cmd_a = '0, cmd_b = '0, src, dst;
  logic [W-1:0] cmd_imm = '0, d_in, d_out, rd_data;
  logic sto, sto_alu, done;
  logic [W-1:0] rf [128];
  logic [W-1:0] ref_m [128];
  logic [W-1:0] acc_val = 16'h0F0F;
  logic ld = 1'b0;
  logic [6:0] ld_addr = '0;
  logic [W-1:0] ld_val = '0;
  int checks = 0, errors = 0;
  int sto_cnt = 0, alu_cnt = 0, done_cnt = 0, bad_cnt = 0;
  logic [31:0] got_w [$];

  always #5 clk = ~clk;

  mr_reg_seq #(.W(W), .ACC_CYCLES(ACC_CY), .ACC_ADDR(ACC_AD)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_imm_i(cmd_imm),
    .src_o(src), .dst_o(dst), .d_in_o(d_in), .sto_o(sto), .sto_alu_o(sto_alu),
    .d_out_i(d_out), .done_o(done), .rd_data_o(rd_data));

  assign d_out = (src == ACC_AD) ? acc_val : rf[src[6:0]];

  always @(posedge clk) begin
    if (ld) rf[ld_addr] <= ld_val;
    else if (sto) rf[dst[6:0]] <= d_in;
  end

  always @(negedge clk) begin
    if (sto) begin
      sto_cnt++;
      got_w.push_back({dst, d_in});
    end
    if (sto_alu) alu_cnt++;
    if (done) done_cnt++;
    if (sto && sto_alu) bad_cnt++;
    if (!sto && (dst != 0 || d_in != 0)) bad_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic poke(input logic [6:0] a, input logic [W-1:0] v);
    @(negedge clk);
    ld = 1'b1; ld_addr = a; ld_val = v;
    @(posedge clk); #1;
    ld = 1'b0;
    ref_m[a] = v;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [W-1:0] imm, input string nm);
    logic [W-1:0] exp_rd, tmp;
    logic [31:0] exp_w [$];
    int exp_lat, exp_alu, lat, a0, busy_rdy, mm;
    exp_w = {};
    case (op)
      2'd0: begin
        exp_rd = ref_m[b[6:0]]; ref_m[a[6:0]] = exp_rd;
        exp_w.push_back({a, exp_rd}); exp_lat = 3; exp_alu = 0;
      end
      2'd1: begin
        exp_rd = imm; ref_m[a[6:0]] = imm;
        exp_w.push_back({a, imm}); exp_lat = 2; exp_alu = 0;
      end
      2'd2: begin
        exp_rd = ref_m[a[6:0]]; tmp = ref_m[b[6:0]];
        exp_w.push_back({a, tmp}); exp_w.push_back({b, exp_rd});
        ref_m[a[6:0]] = tmp; ref_m[b[6:0]] = exp_rd;
        exp_lat = 5; exp_alu = 0;
      end
      default: begin
        exp_rd = acc_val; exp_lat = ACC_CY + 2; exp_alu = ACC_CY;
      end
    endcase
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before got %b want 1", nm, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_imm = W'($urandom);
    a0 = alu_cnt; got_w = {};
    lat = 0; busy_rdy = 0;
    do begin
      @(negedge clk); #1;
      lat++;
      if (cmd_ready) busy_rdy++;
    end while (!done && lat < 40);
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency got %0d want %0d", nm, lat, exp_lat);
    end
    checks++;
    if (busy_rdy !== 0) begin
      errors++; $display("FAIL %s ready_busy got %0d want 0", nm, busy_rdy);
    end
    checks++;
    if (rd_data !== exp_rd) begin
      errors++; $display("FAIL %s rd_data_at_done got %h want %h", nm, rd_data, exp_rd);
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || rd_data !== exp_rd) begin
      errors++; $display("FAIL %s after_done done=%b ready=%b rd=%h want 0 1 %h", nm, done, cmd_ready, rd_data, exp_rd);
    end
    checks++;
    if (alu_cnt - a0 !== exp_alu) begin
      errors++; $display("FAIL %s sto_alu_cycles got %0d want %0d", nm, alu_cnt - a0, exp_alu);
    end
    checks++;
    if (got_w != exp_w) begin
      errors++; $display("FAIL %s writes got %0d entries %p want %0d entries %p", nm, got_w.size(), got_w, exp_w.size(), exp_w);
    end
    mm = 0;
    for (int i = 0; i < 128; i++) if (rf[i] !== ref_m[i]) mm++;
    checks++;
    if (mm !== 0) begin
      errors++; $display("FAIL %s regfile mismatched_entries got %0d want 0", nm, mm);
    end
    checks++;
    if (bad_cnt !== 0) begin
      errors++; $display("FAIL %s output_rules violations got %0d want 0", nm, bad_cnt);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({cmd_ready, sto, sto_alu, done, src, dst, d_in, rd_data} !== '0) begin
      errors++; $display("FAIL reset_outputs got ready=%b sto=%b alu=%b done=%b src=%h dst=%h din=%h rd=%h want all 0",
                         cmd_ready, sto, sto_alu, done, src, dst, d_in, rd_data);
    end
    for (int i = 0; i < 128; i++) poke(7'(i), W'($urandom));
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_ldi();
    do_cmd(2'd1, 16'h0003, 16'h0000, 16'hBEEF, "ldi");
  endtask

  task automatic test_mov();
    poke(7'h02, 16'h1234);
    do_cmd(2'd0, 16'h0001, 16'h0002, 16'h0000, "mov");
  endtask

  task automatic test_swap();
    poke(7'h41, 16'h00AA);
    poke(7'h05, 16'h5555);
    do_cmd(2'd2, 16'h0041, 16'h0005, 16'h0000, "swap");
  endtask

  task automatic test_acc();
    acc_val = 16'h0F0F;
    do_cmd(2'd3, 16'h0000, 16'h0000, 16'h0000, "acc");
  endtask

  task automatic test_same_addr();
    do_cmd(2'd0, 16'h0007, 16'h0007, 16'h0000, "mov_same");
    do_cmd(2'd2, 16'h000C, 16'h000C, 16'h0000, "swap_same");
  endtask

  task automatic test_back_to_back();
    int n, busy_rdy;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_a = 16'h0010; cmd_imm = 16'h1111;
    @(posedge clk); #1;
    cmd_a = 16'h0011; cmd_imm = 16'h2222;
    ref_m[16] = 16'h1111;
    n = 0; busy_rdy = 0;
    do begin
      @(negedge clk); #1;
      n++;
      if (cmd_ready) busy_rdy++;
    end while (!done && n < 40);
    checks++;
    if (n !== 2 || busy_rdy !== 0 || rd_data !== 16'h1111) begin
      errors++; $display("FAIL b2b_first lat=%0d ready_busy=%0d rd=%h want 2 0 1111", n, busy_rdy, rd_data);
    end
    @(negedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle ready got %b want 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    ref_m[17] = 16'h2222;
    @(negedge clk); #1;
    checks++;
    if (sto !== 1'b1 || dst !== 16'h0011 || d_in !== 16'h2222) begin
      errors++; $display("FAIL b2b_second_write sto=%b dst=%h din=%h want 1 0011 2222", sto, dst, d_in);
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b1 || rd_data !== 16'h2222) begin
      errors++; $display("FAIL b2b_second_done done=%b rd=%h want 1 2222", done, rd_data);
    end
    @(negedge clk); #1;
    checks++;
    if (rf[16] !== 16'h1111 || rf[17] !== 16'h2222) begin
      errors++; $display("FAIL b2b_regs got %h %h want 1111 2222", rf[16], rf[17]);
    end
  endtask

  task automatic test_reset_mid();
    int d0, mm;
    poke(7'h20, 16'hA5A5);
    poke(7'h21, 16'h5A5A);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_a = 16'h0020; cmd_b = 16'h0021;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sto !== 1'b1 || dst !== 16'h0020) begin
      errors++; $display("FAIL rst_mid_in_wr_a sto=%b dst=%h want 1 0020", sto, dst);
    end
    d0 = done_cnt;
    rst = 1'b1; #1;
    checks++;
    if ({cmd_ready, sto, sto_alu, done, src, dst, d_in} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs ready=%b sto=%b alu=%b done=%b src=%h dst=%h din=%h want all 0",
                         cmd_ready, sto, sto_alu, done, src, dst, d_in);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_release ready got %b want 1", cmd_ready);
    end
    repeat (6) @(negedge clk);
    #1;
    mm = 0;
    for (int i = 0; i < 128; i++) if (rf[i] !== ref_m[i]) mm++;
    checks++;
    if (done_cnt !== d0 || mm !== 0) begin
      errors++; $display("FAIL rst_mid_aftermath done_pulses=%0d mismatches=%0d want 0 0", done_cnt - d0, mm);
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      acc_val = W'($urandom);
      do_cmd(op, 16'($urandom_range(0, 79)), 16'($urandom_range(0, 79)), W'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_mov();
    test_swap();
    test_acc();
    test_same_addr();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
